// File: rtl/ft_cmd_engine.sv
// ft_cmd_engine: multi-byte host command parser between the FT2232H FIFO
// bridge and the pulse-echo datapath. Opcodes: 0x7 loopback, 0x1 register
// write (NB payload bytes, MSB first), 0x2 register read. Keeps a
// NUM_REGS x REG_W register file, a per-byte payload timeout and a
// saturating error counter.
// Optional build macro CMD_ACK_EN: adds an ACK state that answers every
// write command (0xA0|addr ok, 0xE0|addr bad address, 0xEF timeout).
module ft_cmd_engine #(
  parameter int NUM_REGS = 8,
  parameter int REG_W    = 16,
  parameter int TIMEOUT  = 1024
) (
  input  logic                      clk,
  input  logic                      rst_n,
  output logic                      rd_en,
  input  logic [7:0]                rd_data,
  input  logic                      rd_empty,
  output logic                      wr_en,
  output logic [7:0]                wr_data,
  input  logic                      wr_full,
  output logic [NUM_REGS*REG_W-1:0] reg_file,
  output logic [NUM_REGS-1:0]       reg_wr_stb,
  output logic [7:0]                err_cnt,
  output logic                      busy
);

  localparam int NB = REG_W / 8;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [3:0] {
    IDLE,
    CMD_CAP,
    DECODE,
    LOOP,
    PAY_REQ,
    PAY_CAP,
    COMMIT,
    RESP
`ifdef CMD_ACK_EN
    , ACK
`endif
  } state_t;

  state_t           state;
  logic [7:0]       cmd;
  logic [REG_W-1:0] payload;
  logic [2:0]       cnt;
  logic [TW-1:0]    tmo_cnt;
  logic [REG_W-1:0] regs [NUM_REGS];
  logic [REG_W-1:0] sel_reg;
  logic [7:0]       resp_byte;
  logic [3:0]       opcode;
  logic [3:0]       addr;
  logic             addr_ok;
`ifdef CMD_ACK_EN
  logic [7:0]       ack_byte;
`endif

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign opcode  = cmd[7:4];
  assign addr    = cmd[3:0];
  assign addr_ok = ({1'b0, addr} < 5'(NUM_REGS));
  assign busy    = (state != IDLE);

  // Response byte: selected register (zero when out of range), byte cnt.
  always_comb begin
    sel_reg = '0;
    for (int unsigned k = 0; k < NUM_REGS; k++) begin
      if (addr == 4'(k)) sel_reg = regs[k];
    end
    resp_byte = 8'(sel_reg >> {cnt, 3'b000});
  end

  // Flatten the register file onto the output bus.
  always_comb begin
    reg_file = '0;
    for (int unsigned k = 0; k < NUM_REGS; k++) begin
      reg_file[k*REG_W +: REG_W] = regs[k];
    end
  end

  // Command FSM with registered strobes, data and register file.
  // rd_en is registered, so it is high during the first cycle of CMD_CAP /
  // PAY_CAP and the bridge data is valid in the cycle after; the capture
  // states therefore wait while rd_en is still high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      rd_en      <= 1'b0;
      wr_en      <= 1'b0;
      wr_data    <= '0;
      reg_wr_stb <= '0;
      err_cnt    <= '0;
      cmd        <= '0;
      payload    <= '0;
      cnt        <= '0;
      tmo_cnt    <= '0;
      for (int unsigned k = 0; k < NUM_REGS; k++) regs[k] <= '0;
`ifdef CMD_ACK_EN
      ack_byte   <= '0;
`endif
    end else begin
      rd_en      <= 1'b0;
      wr_en      <= 1'b0;
      reg_wr_stb <= '0;
      case (state)
        IDLE: begin
          if (!rd_empty) begin
            rd_en <= 1'b1;
            state <= CMD_CAP;
          end
        end
        CMD_CAP: begin
          if (!rd_en) begin
            cmd   <= rd_data;
            state <= DECODE;
          end
        end
        DECODE: begin
          case (opcode)
            4'h7: state <= LOOP;
            4'h1: begin
              cnt     <= 3'(NB);
              tmo_cnt <= '0;
              payload <= '0;
              state   <= PAY_REQ;
            end
            4'h2: begin
              cnt <= 3'(NB - 1);
              if (!addr_ok) err_cnt <= sat_inc(err_cnt);
              state <= RESP;
            end
            default: begin
              err_cnt <= sat_inc(err_cnt);
              state   <= IDLE;
            end
          endcase
        end
        LOOP: begin
          if (!wr_en && !wr_full) begin
            wr_en   <= 1'b1;
            wr_data <= cmd;
            state   <= IDLE;
          end
        end
        PAY_REQ: begin
          if (!rd_empty) begin
            rd_en   <= 1'b1;
            tmo_cnt <= '0;
            state   <= PAY_CAP;
          end else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
            err_cnt <= sat_inc(err_cnt);
            tmo_cnt <= '0;
`ifdef CMD_ACK_EN
            ack_byte <= 8'hEF;
            state    <= ACK;
`else
            state    <= IDLE;
`endif
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        PAY_CAP: begin
          if (!rd_en) begin
            payload <= (payload << 8) | REG_W'(rd_data);
            cnt     <= cnt - 3'd1;
            state   <= (cnt == 3'd1) ? COMMIT : PAY_REQ;
          end
        end
        COMMIT: begin
          for (int unsigned k = 0; k < NUM_REGS; k++) begin
            if (addr == 4'(k)) begin
              regs[k]       <= payload;
              reg_wr_stb[k] <= 1'b1;
            end
          end
          if (!addr_ok) err_cnt <= sat_inc(err_cnt);
`ifdef CMD_ACK_EN
          ack_byte <= addr_ok ? {4'hA, addr} : {4'hE, addr};
          state    <= ACK;
`else
          state    <= IDLE;
`endif
        end
        RESP: begin
          if (!wr_en && !wr_full) begin
            wr_en   <= 1'b1;
            wr_data <= resp_byte;
            if (cnt == 3'd0) state <= IDLE;
            else             cnt   <= cnt - 3'd1;
          end
        end
`ifdef CMD_ACK_EN
        ACK: begin
          if (!wr_en && !wr_full) begin
            wr_en   <= 1'b1;
            wr_data <= ack_byte;
            state   <= IDLE;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ft_cmd_engine.sv
// Scoreboard bench for ft_cmd_engine: a bridge model feeds host bytes from
// a queue; a command-level reference model pushes expected TX bytes and
// register updates; a monitor pops and compares on wr_en / reg_wr_stb.
module tb_ft_cmd_engine;
  localparam int NR = 8;
  localparam int RW = 16;
  localparam int TO = 64;
  localparam int NB = RW / 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rd_en;
  logic [7:0]    rd_data = 8'h00;
  logic          rd_empty = 1'b1;
  logic          wr_en;
  logic [7:0]    wr_data;
  logic          wr_full = 1'b0;
  logic [NR*RW-1:0] reg_file;
  logic [NR-1:0] reg_wr_stb;
  logic [7:0]    err_cnt;
  logic          busy;

  ft_cmd_engine #(.NUM_REGS(NR), .REG_W(RW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .rd_en(rd_en), .rd_data(rd_data), .rd_empty(rd_empty),
    .wr_en(wr_en), .wr_data(wr_data), .wr_full(wr_full),
    .reg_file(reg_file), .reg_wr_stb(reg_wr_stb),
    .err_cnt(err_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct { int addr; logic [RW-1:0] val; } stb_t;

  int total = 0;
  int bad = 0;
  logic [7:0] rx_q[$];
  logic [7:0] exp_tx[$];
  stb_t       exp_stb[$];
  logic [RW-1:0] m_regs [NR];
  int m_err = 0;
  int cyc = 0;
  int last_rd_cyc = 0;
  int rd_events = 0;
  int wr_events = 0;
  logic rand_full = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int sat(input int e);
    return (e > 255) ? 255 : e;
  endfunction

  // Bridge model and monitor: everything sampled on the falling edge.
  initial begin
    logic full_at_p;
    logic prev_rd;
    stb_t s;
    prev_rd = 1'b0;
    forever begin
      @(posedge clk);
      cyc++;
      full_at_p = wr_full;
      @(negedge clk);
      if (rd_en) begin
        rd_events++;
        chk("rd_en_consecutive", 32'(prev_rd), 0);
        chk("rd_en_with_data", 32'(rx_q.size() > 0), 1);
        if (rx_q.size() > 0) begin
          rd_data = rx_q.pop_front();
          last_rd_cyc = cyc;
        end
      end
      prev_rd = rd_en;
      rd_empty = (rx_q.size() == 0);
      if (wr_en) begin
        wr_events++;
        chk("wr_while_full", 32'(full_at_p), 0);
        total++;
        if (exp_tx.size() == 0) begin
          bad++;
          $display("FAIL tx_extra: got %0h expected no byte", wr_data);
        end else begin
          logic [7:0] e;
          e = exp_tx.pop_front();
          if (wr_data !== e) begin
            bad++;
            $display("FAIL tx_byte: got %0h expected %0h", wr_data, e);
          end
        end
      end
      if (reg_wr_stb != '0) begin
        total++;
        if (exp_stb.size() == 0) begin
          bad++;
          $display("FAIL stb_extra: got %0h expected 0", reg_wr_stb);
        end else begin
          total--;
          s = exp_stb.pop_front();
          chk("stb_onehot", 32'(reg_wr_stb), 32'(1 << s.addr));
          chk("stb_reg_value", 32'(reg_file[s.addr*RW +: RW]), 32'(s.val));
        end
      end
    end
  end

  // Random TX backpressure when enabled.
  initial begin
    forever begin
      @(negedge clk);
      if (rand_full) wr_full = ($urandom_range(0, 3) == 0);
    end
  end

  task automatic cmd_write(input int a, input logic [RW-1:0] v);
    rx_q.push_back({4'h1, 4'(a)});
    for (int i = NB - 1; i >= 0; i--) rx_q.push_back(v[i*8 +: 8]);
    if (a < NR) begin
      m_regs[a] = v;
      exp_stb.push_back('{a, v});
`ifdef CMD_ACK_EN
      exp_tx.push_back({4'hA, 4'(a)});
`endif
    end else begin
      m_err++;
`ifdef CMD_ACK_EN
      exp_tx.push_back({4'hE, 4'(a)});
`endif
    end
  endtask

  task automatic cmd_read(input int a);
    logic [RW-1:0] v;
    rx_q.push_back({4'h2, 4'(a)});
    if (a < NR) v = m_regs[a];
    else begin
      v = '0;
      m_err++;
    end
    for (int i = NB - 1; i >= 0; i--) exp_tx.push_back(v[i*8 +: 8]);
  endtask

  task automatic cmd_loop(input logic [3:0] lo);
    rx_q.push_back({4'h7, lo});
    exp_tx.push_back({4'h7, lo});
  endtask

  task automatic cmd_bad(input logic [3:0] op, input logic [3:0] lo);
    rx_q.push_back({op, lo});
    m_err++;
  endtask

  task automatic wait_done(input string nm);
    int n;
    n = 0;
    while ((rx_q.size() != 0 || busy || exp_tx.size() != 0 || exp_stb.size() != 0) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    chk({nm, "_completed"}, 32'(n < 5000), 1);
    chk({nm, "_err_cnt"}, 32'(err_cnt), 32'(sat(m_err)));
    chk({nm, "_busy"}, 32'(busy), 0);
  endtask

  task automatic check_regs(input string nm);
    for (int k = 0; k < NR; k++)
      chk({nm, "_reg"}, 32'(reg_file[k*RW +: RW]), 32'(m_regs[k]));
  endtask

  initial begin
    int w0;
    int r0;
    int n;
    int gap;
    int sel;
    for (int k = 0; k < NR; k++) m_regs[k] = '0;

    repeat (3) @(negedge clk);
    chk("rst_rd_en", 32'(rd_en), 0);
    chk("rst_wr_en", 32'(wr_en), 0);
    chk("rst_wr_data", 32'(wr_data), 0);
    chk("rst_stb", 32'(reg_wr_stb), 0);
    chk("rst_err_cnt", 32'(err_cnt), 0);
    chk("rst_busy", 32'(busy), 0);
    check_regs("rst");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Write then read back register 2.
    w0 = wr_events;
    cmd_write(2, 16'hABCD);
    wait_done("write2");
    check_regs("write2");
`ifdef CMD_ACK_EN
    chk("write2_tx_count", 32'(wr_events - w0), 1);
`else
    chk("write2_tx_count", 32'(wr_events - w0), 0);
`endif
    cmd_read(2);
    wait_done("read2");
    check_regs("read2");

    // Loopback held off by a full TX FIFO.
    wr_full = 1'b1;
    w0 = wr_events;
    cmd_loop(4'h5);
    repeat (10) @(negedge clk);
    chk("bp_no_wr", 32'(wr_events - w0), 0);
    wr_full = 1'b0;
    wait_done("loop_bp");
    chk("bp_one_wr", 32'(wr_events - w0), 1);

    // Truncated write to reg 3: payload timeout.
    rx_q.push_back(8'h13);
    rx_q.push_back(8'h55);
    m_err++;
`ifdef CMD_ACK_EN
    exp_tx.push_back(8'hEF);
`endif
    n = 0;
    while (!busy && n < 100) begin @(negedge clk); n++; end
    n = 0;
    while (busy && n < 500) begin @(negedge clk); n++; end
    gap = cyc - last_rd_cyc;
    total++;
    if (gap < TO || gap > TO + 6) begin
      bad++;
      $display("FAIL timeout_gap: got %0d expected %0d..%0d", gap, TO, TO + 6);
    end
    wait_done("timeout");
    check_regs("timeout");

    // Bad opcode and out-of-range write.
    cmd_bad(4'hF, 4'h0);
    cmd_write(10, 16'h0102);
    wait_done("errors");
    check_regs("errors");

    // Address boundaries.
    cmd_write(0, 16'h1234);
    cmd_write(NR - 1, 16'hFEDC);
    cmd_write(15, 16'h5A5A);
    cmd_read(NR - 1);
    cmd_read(NR);
    cmd_read(0);
    wait_done("bounds");
    check_regs("bounds");

    // Randomised command stream with random backpressure.
    rand_full = 1'b1;
    for (int i = 0; i < 60; i++) begin
      sel = $urandom_range(0, 9);
      if (sel < 4)      cmd_write($urandom_range(0, 9), RW'($urandom));
      else if (sel < 7) cmd_read($urandom_range(0, 9));
      else if (sel < 9) cmd_loop(4'($urandom_range(0, 15)));
      else              cmd_bad(4'($urandom_range(3, 6)), 4'($urandom_range(0, 15)));
      if ($urandom_range(0, 2) == 0) wait_done("rand_step");
    end
    wait_done("rand_end");
    rand_full = 1'b0;
    @(negedge clk);
    wr_full = 1'b0;
    check_regs("rand");

    // Error counter saturation.
    for (int i = 0; i < 260; i++) cmd_bad(4'h0, 4'($urandom_range(0, 15)));
    wait_done("saturate");
    chk("saturate_ff", 32'(err_cnt), 32'hFF);

    // Reset in the middle of a read response.
    m_regs[2] = 16'hBEEF;
    exp_stb.push_back('{2, 16'hBEEF});
`ifdef CMD_ACK_EN
    exp_tx.push_back(8'hA2);
`endif
    rx_q.push_back(8'h12);
    rx_q.push_back(8'hBE);
    rx_q.push_back(8'hEF);
    wait_done("pre_reset_write");
    cmd_read(2);
    n = 0;
    while (!wr_en && n < 200) begin @(negedge clk); n++; end
    chk("reset_first_byte_seen", 32'(n < 200), 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_wr_en", 32'(wr_en), 0);
    chk("mid_rst_err_cnt", 32'(err_cnt), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_stb", 32'(reg_wr_stb), 0);
    exp_tx.delete();
    m_err = 0;
    for (int k = 0; k < NR; k++) m_regs[k] = '0;
    check_regs("mid_rst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    r0 = rd_events;
    w0 = wr_events;
    repeat (10) @(negedge clk);
    chk("post_rst_idle_busy", 32'(busy), 0);
    chk("post_rst_no_rd", 32'(rd_events - r0), 0);
    chk("post_rst_no_wr", 32'(wr_events - w0), 0);
    cmd_write(1, 16'hC0DE);
    cmd_read(1);
    wait_done("post_rst");
    check_regs("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "global timeout");
  end

endmodule
